fetch_if_id_stage: RTL and testbench
====================================

Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the hazard detection unit.
- Owns the PC, drives the instruction-memory address, and registers the fetched word into IF/ID.
- Honours hold_pc / hold_if_id from hazard detection and branch redirect/flush from the ID-stage branch compare.
- Its if_id_instr output is the IF_ID_Instr input of hazard detection.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- hold_pc  in  1  from hazard detection; freeze the PC.
- hold_if_id  in  1  from hazard detection; freeze the IF/ID register.
- branch_taken  in  1  ID-stage branch resolved taken; redirect the PC and flush IF/ID.
- branch_target  in  32  redirect address, valid when branch_taken=1.
- imem_addr  out  32  instruction memory address, equal to pc (combinational from the PC register).
- imem_rdata  in  32  instruction word, combinational read of imem_addr in the same cycle.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  registered instruction presented to ID and hazard detection.
- if_id_pc_plus4  out  32  registered pc+PC_STEP of the instruction in ID.
- if_id_valid  out  1  1 = ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-stall):
  - pc=RESET_PC.
  - if_id_instr=32'h0000_0000 (NOP), if_id_pc_plus4=0, if_id_valid=0.
  - FSM=BOOT. Counters cleared.
- FSM, two states:
  - BOOT: first cycle after reset deassertion. PC does not advance; IF/ID stays NOP/invalid. This absorbs the first memory read. Unconditional next state RUN.
  - RUN: normal operation. Left only by reset.
- PC update in RUN, at each rising edge, in priority order:
  - branch_taken=1: pc<=branch_target. Redirect wins over hold_pc.
  - else hold_pc=1: pc unchanged.
  - else: pc<=pc+PC_STEP. Modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- IF/ID update in RUN, at each rising edge, in priority order:
  - branch_taken=1: if_id_instr<=NOP, if_id_valid<=0, if_id_pc_plus4<=0. Flush wins over hold_if_id.
  - else hold_if_id=1: all IF/ID outputs unchanged.
  - else: if_id_instr<=imem_rdata, if_id_pc_plus4<=pc+PC_STEP, if_id_valid<=1.
- Latency: an instruction at address A appears on if_id_instr one edge after pc=A, absent holds.
- hold_pc=1 with hold_if_id=0: IF/ID re-captures the same word every cycle (legal, idempotent).
- hold_pc=0 with hold_if_id=1: the fetched word is lost. Hazard detection never issues this; the bench flags it as an assertion warning, not an error.
- Hold inputs are sampled only at clock edges. Glitches between edges have no effect.
- No combinational path from any input to if_id_* or pc.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds two outputs, perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments on each RUN-state edge with hold_pc=1 and branch_taken=0.
  - perf_flush_cnt increments on each RUN-state edge with branch_taken=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR (32'h0).
  - INSTR_W=32, PC_W=32.
  - Opcode constants, including BEQ 6'b000100.
  - fetch_state_t enum {BOOT, RUN}.
- One sub-module, if_id_reg: holds instr, pc_plus4 and valid, with flush > hold > load priority. It is reused later for the ID/EX register pattern.
- The top level holds the PC register, next-PC mux, FSM and optional counters.

Test Plan:
- Reset release, imem returns word = address | 32'hA000_0000, no holds: pc sequence 0,0,4,8,…; if_id_instr 32'hA000_0000 two edges after reset release, if_id_valid=1.
- hold_pc=hold_if_id=1 for 3 cycles with pc=0x10: pc stays 0x10 and if_id_instr frozen for 3 edges; resumes at 0x14.
- branch_taken=1, branch_target=0x200, with hold_pc=hold_if_id=1 in the same cycle: next edge gives pc=0x200, if_id_instr=0, if_id_valid=0; the following edge loads word from 0x200.
- Drive pc to 0xFFFF_FFFC via a branch, no holds: next pc=0x0000_0000, if_id_pc_plus4=0x0000_0000.
- rst_n pulsed low mid-stall (asynchronously, between edges): outputs go immediately to pc=RESET_PC, NOP, valid=0; BOOT cycle is repeated.
- With FETCH_PERF_CNT_EN defined, run 5 stall cycles and 2 branches: perf_stall_cnt=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/mips_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg : shared widths, opcodes and fetch-stage state encoding.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;

   localparam int INSTR_W = 32;
   localparam int PC_W    = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// +----------------------------------------------------------------------+
// | if_id_reg : pipeline register (instr, pc+step, valid) with           |
// |             flush > hold > load priority.                            |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_reg
   import mips_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               hold,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [PC_W-1:0]    load_pc_plus4,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc_plus4,
   output logic               valid
);

   logic [INSTR_W-1:0] r_instr;
   logic [PC_W-1:0]    r_pc_plus4;
   logic               r_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (flush) begin
         r_instr    <= NOP_INSTR;
         r_pc_plus4 <= '0;
         r_valid    <= 1'b0;
      end else if (!hold) begin
         r_instr    <= load_instr;
         r_pc_plus4 <= load_pc_plus4;
         r_valid    <= 1'b1;
      end
   end

   assign instr    = r_instr;
   assign pc_plus4 = r_pc_plus4;
   assign valid    = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_if_id_stage.sv
// +----------------------------------------------------------------------+
// | fetch_if_id_stage : PC register, next-PC mux, BOOT/RUN FSM and IF/ID |
// |   register. Optional macro FETCH_PERF_CNT_EN adds stall/flush counts. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module fetch_if_id_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               hold_pc,
   input  logic               hold_if_id,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [PC_W-1:0]    pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt,
`endif
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [PC_W-1:0]    if_id_pc_plus4,
   output logic               if_id_valid
);

   localparam logic [PC_W-1:0] c_pc_step = PC_W'(PC_STEP);

   fetch_state_t    r_state;
   fetch_state_t    w_state_nxt;
   logic            w_run;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_plus_step;
   logic [PC_W-1:0] w_pc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= BOOT;
      else        r_state <= w_state_nxt;
   end

   // BOOT only lasts one cycle; RUN is left by reset alone.
   always_comb begin
      w_state_nxt = RUN;
      w_run       = 1'b0;
      case (r_state)
         BOOT:    w_state_nxt = RUN;
         RUN:     w_run       = 1'b1;
         default: w_state_nxt = RUN;
      endcase
   end

   assign w_pc_plus_step = r_pc + c_pc_step;

   always_comb begin
      w_pc_nxt = r_pc;
      if (w_run) begin
         if (branch_taken)  w_pc_nxt = branch_target;
         else if (!hold_pc) w_pc_nxt = w_pc_plus_step;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pc <= RESET_PC;
      else        r_pc <= w_pc_nxt;
   end

   assign pc        = r_pc;
   assign imem_addr = r_pc;

   // In BOOT the register is simply held at its reset NOP/invalid value.
   if_id_reg u_if_id_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (w_run & branch_taken),
      .hold          (~w_run | hold_if_id),
      .load_instr    (imem_rdata),
      .load_pc_plus4 (w_pc_plus_step),
      .instr         (if_id_instr),
      .pc_plus4      (if_id_pc_plus4),
      .valid         (if_id_valid)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (w_run) begin
         if (hold_pc && !branch_taken && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (branch_taken && (r_flush_cnt != 32'hFFFF_FFFF))
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_if_id_stage.sv
// +----------------------------------------------------------------------+
// | tb_fetch_if_id_stage : directed self-checking bench for the fetch    |
// |   stage; imem model returns address | 32'hA000_0000.                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_if_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hold_pc;
   logic        hold_if_id;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr | 32'hA000_0000;

   fetch_if_id_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .hold_pc        (hold_pc),
      .hold_if_id     (hold_if_id),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .pc             (pc),
`ifdef FETCH_PERF_CNT_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid)
   );

   always @(posedge clk)
      if (rst_n && !hold_pc && hold_if_id && !branch_taken)
         $warning("hold_if_id without hold_pc drops a fetched word");

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      hold_pc = 0; hold_if_id = 0; branch_taken = 0; branch_target = '0;
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
      n_checks++;
      if (if_id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'h0); end
      n_checks++;
      if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
      n_checks++;
      if (if_id_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h expected %h", if_id_pc_plus4, 32'h0); end
   endtask

   task automatic test_sequential();
      tick(); // BOOT edge
      n_checks++;
      if (pc !== 32'h0 || if_id_valid !== 1'b0) begin
         n_fail++; $display("FAIL boot_edge: pc=%h valid=%b expected pc=0 valid=0", pc, if_id_valid);
      end
      // A glitch on hold_pc between edges must have no effect.
      #2 hold_pc = 1; #1 hold_pc = 0;
      tick();
      n_checks++;
      if (pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1: got %h expected %h", pc, 32'h4); end
      n_checks++;
      if (if_id_instr !== 32'hA000_0000 || if_id_valid !== 1'b1) begin
         n_fail++; $display("FAIL seq_instr1: got %h/%b expected a0000000/1", if_id_instr, if_id_valid);
      end
      n_checks++;
      if (if_id_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL seq_pc4: got %h expected %h", if_id_pc_plus4, 32'h4); end
      tick();
      n_checks++;
      if (pc !== 32'h8 || if_id_instr !== 32'hA000_0004) begin
         n_fail++; $display("FAIL seq_pc2: pc=%h instr=%h expected 8/a0000004", pc, if_id_instr);
      end
   endtask

   task automatic test_hold();
      repeat (2) tick(); // pc: 0xC, 0x10
      n_checks++;
      if (pc !== 32'h10 || if_id_instr !== 32'hA000_000C) begin
         n_fail++; $display("FAIL hold_setup: pc=%h instr=%h expected 10/a000000c", pc, if_id_instr);
      end
      hold_pc = 1; hold_if_id = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc !== 32'h10 || if_id_instr !== 32'hA000_000C || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_cycle%0d: pc=%h instr=%h expected 10/a000000c", i, pc, if_id_instr);
         end
      end
      hold_pc = 0; hold_if_id = 0;
      tick();
      n_checks++;
      if (pc !== 32'h14 || if_id_instr !== 32'hA000_0010 || if_id_pc_plus4 !== 32'h14) begin
         n_fail++; $display("FAIL hold_resume: pc=%h instr=%h pc4=%h expected 14/a0000010/14", pc, if_id_instr, if_id_pc_plus4);
      end
   endtask

   task automatic test_branch_over_hold();
      branch_taken = 1; branch_target = 32'h200; hold_pc = 1; hold_if_id = 1;
      tick();
      n_checks++;
      if (pc !== 32'h200) begin n_fail++; $display("FAIL br_pc: got %h expected %h", pc, 32'h200); end
      n_checks++;
      if (if_id_instr !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin
         n_fail++; $display("FAIL br_flush: instr=%h valid=%b pc4=%h expected 0/0/0", if_id_instr, if_id_valid, if_id_pc_plus4);
      end
      branch_taken = 0; hold_pc = 0; hold_if_id = 0;
      tick();
      n_checks++;
      if (if_id_instr !== 32'hA000_0200 || if_id_valid !== 1'b1 || pc !== 32'h204) begin
         n_fail++; $display("FAIL br_load: instr=%h valid=%b pc=%h expected a0000200/1/204", if_id_instr, if_id_valid, pc);
      end
   endtask

   task automatic test_wrap();
      branch_taken = 1; branch_target = 32'hFFFF_FFFC;
      tick();
      branch_taken = 0;
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc", pc, 32'h0);
      chk("wrap_pc4", if_id_pc_plus4, 32'h0);
      chk("wrap_instr", if_id_instr, 32'hFFFF_FFFC);
   endtask

   task automatic test_async_reset();
      hold_pc = 1; hold_if_id = 1;
      repeat (2) tick();
      #2 rst_n = 0;
      #1;
      n_checks++;
      if (pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_valid !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: pc=%h instr=%h valid=%b expected 0/0/0", pc, if_id_instr, if_id_valid);
      end
      @(negedge clk);
      hold_pc = 0; hold_if_id = 0;
      rst_n = 1;
      tick();
      n_checks++;
      if (pc !== 32'h0 || if_id_valid !== 1'b0) begin
         n_fail++; $display("FAIL reboot_edge: pc=%h valid=%b expected 0/0", pc, if_id_valid);
      end
      tick();
      n_checks++;
      if (pc !== 32'h4 || if_id_instr !== 32'hA000_0000 || if_id_valid !== 1'b1) begin
         n_fail++; $display("FAIL reboot_run: pc=%h instr=%h expected 4/a0000000", pc, if_id_instr);
      end
   endtask

`ifdef FETCH_PERF_CNT_EN
   task automatic test_perf();
      apply_reset();
      n_checks++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         n_fail++; $display("FAIL perf_reset: stall=%0d flush=%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
      end
      tick(); // BOOT
      hold_pc = 1; hold_if_id = 1;
      repeat (5) tick();
      hold_pc = 0; hold_if_id = 0;
      branch_taken = 1; branch_target = 32'h40;
      repeat (2) tick();
      branch_taken = 0;
      tick();
      n_checks++;
      if (perf_stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cnt); end
      n_checks++;
      if (perf_flush_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_sequential();
      test_hold();
      test_branch_over_hold();
      test_wrap();
      test_async_reset();
`ifdef FETCH_PERF_CNT_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
